// File: rtl/cpu_clock_pkg.sv
// Shared types and default sizing for the CPU clock-enable controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_clock_pkg;

  // Run modes and FSM states share one encoding, so the next state is simply the mode.
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } state_t;

  typedef state_t mode_t;

  localparam int DIV_W_DEF   = 18;
  localparam int DEB_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/cpu_clock_ctl_btn_debounce.sv
// Synchronises and debounces a raw push-button, and flags each debounced rising edge.
// Latency: 2 sync + 2^DEB_W stable clocks to level, +1 clock to rise.
// Backpressure: none; rise is a free-running one-cycle pulse.
module btn_debounce #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [DEB_W-1:0] stable_cnt;

  // Two-flop synchroniser, stability counter and registered edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      rise       <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (&stable_cnt) begin
        // Input has disagreed with the level for the full window: accept it.
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctl.sv
// CPU clock-enable controller: halt / free-run / single-step / counted-burst enables on clk.
// Latency: cpu_ce is registered, one clock after the qualifying tick, press or burst cycle.
// Backpressure: none; halt_req, halted or a mode change suppress the next enable.
module cpu_clock_ctl
  import cpu_clock_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEB_W   = DEB_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [4:0]         div_sel,
  input  logic               step_btn,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_go,
  input  logic               halt_req,
  output logic               cpu_ce,
  output logic               busy,
  output logic               halted,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   ce_count
);

  state_t             state_q;
  state_t             state_d;
  logic [DIV_W-1:0]   pre;
  logic [DIV_W-1:0]   mask;
  logic               tick;
  int                 sel_eff;
  logic               btn_level;
  logic               btn_rise;
  logic               press;
  logic [BURST_W-1:0] rem;
  logic [BURST_W-1:0] rem_d;
  logic               busy_d;
  logic               halted_d;
  logic               ce_d;
  logic               mode_chg;
  logic               blocked;

  btn_debounce #(.DEB_W(DEB_W)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (step_btn),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // A step only counts while the debounced button is still held.
  assign press = btn_rise & btn_level;
  assign state = state_q;

  // Tick compare: low min(div_sel, DIV_W) bits of the prescaler all ones.
  always_comb begin
    sel_eff = (int'(div_sel) > DIV_W) ? DIV_W : int'(div_sel);
    mask    = '0;
    for (int i = 0; i < DIV_W; i++) begin
      mask[i] = (i < sel_eff);
    end
    tick = ((pre & mask) == mask);
  end

  // Next state follows mode; compute next enable, burst and halt state.
  always_comb begin
    state_d  = state_t'(mode);
    ce_d     = 1'b0;
    rem_d    = rem;
    busy_d   = busy;
    halted_d = halted;
    mode_chg = (state_t'(mode) != state_q);
    blocked  = halted | halt_req | mode_chg;

    case (state_q)
      ST_RUN:  ce_d = tick;
      ST_STEP: ce_d = press;
      ST_BURST: begin
        if (busy) begin
          if (tick) begin
            ce_d  = 1'b1;
            rem_d = rem - 1'b1;
            if (rem == BURST_W'(1)) busy_d = 1'b0;
          end
        end else if (burst_go) begin
          rem_d  = burst_len;
          busy_d = (burst_len != '0);
        end
      end
      default: ;
    endcase

    // Halt, a pending halt or any mode transition cancels enables and bursts.
    if (blocked) ce_d = 1'b0;
    if (blocked || state_q != ST_BURST) begin
      rem_d  = '0;
      busy_d = 1'b0;
    end

    if (halt_req) begin
      halted_d = 1'b1;
    end else if (state_t'(mode) == ST_HALT) begin
      halted_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALT;
      cpu_ce  <= 1'b0;
      rem     <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_ce  <= ce_d;
      rem     <= rem_d;
      busy    <= busy_d;
      halted  <= halted_d;
    end
  end

  // Free-running prescaler, untouched by mode changes.
  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else     pre <= pre + 1'b1;
  end

  // Wrapping count of delivered enables for the debug display.
  always_ff @(posedge clk) begin
    if (rst) ce_count <= '0;
    else     ce_count <= ce_count + CNT_W'(cpu_ce);
  end

endmodule

// File: doc/cpu_clock_ctl.md
# cpu_clock_ctl

- Parametrised CPU clock-enable controller that replaces the free-running divider bit currently used as the processor clock.
- All sequential logic moves onto the single board clock; the block emits a one-cycle enable (`cpu_ce`) that gates every CPU register and the control FSM.
- Adds four run modes (halt, free-run at a selectable rate, debounced single-step, counted burst), a sticky halt request from the core, and a wrapping enable counter for the seven-segment debug display.

## Interface
Parameters:
- `DIV_W`, 18: prescaler width; maximum run period is 2^DIV_W clocks.
- `DEB_W`, 16: debounce window is 2^DEB_W clocks.
- `BURST_W`, 8: width of the burst length.
- `CNT_W`, 16: width of the `cpu_ce` pulse counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  board clock (12 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  0 = HALT, 1 = RUN, 2 = STEP, 3 = BURST.
- `div_sel`  in  5  RUN/BURST tick period is 2^div_sel clocks; values above DIV_W clamp to DIV_W.
- `step_btn`  in  1  raw, asynchronous, bouncing push-button.
- `burst_len`  in  BURST_W  number of enables per burst.
- `burst_go`  in  1  single-cycle burst start.
- `halt_req`  in  1  core request to stop, for example a halt opcode or state trap.
- `cpu_ce`  out  1  registered, one-cycle CPU enable.
- `busy`  out  1  burst in progress.
- `halted`  out  1  sticky halt flag.
- `state`  out  2  current FSM state, for the debug LED and display.
- `ce_count`  out  CNT_W  number of `cpu_ce` pulses since reset; wraps.

## Operation
- **Prescaler.**
  - `pre` is a free-running DIV_W-bit up-counter.
  - `mask` = (1<<min(div_sel,DIV_W))-1.
  - `tick` = ((pre & mask) == mask). With div_sel=0, `tick` is asserted every cycle.
- **Button path.**
  - `step_btn` passes through a 2-FF synchroniser, then the debouncer.
  - The debounced level changes only after the synchronised input has been stable for 2^DEB_W consecutive clocks.
  - A rising edge of the debounced level produces `press`, a one-cycle pulse.
- **FSM states.** HALT, RUN, STEP, BURST. The next state equals `mode` every cycle.
- **Enable generation.** The next value of `cpu_ce` is computed each cycle t:
  - It is forced to 0 if `halted` or `halt_req` is high at t, or if `mode` changes at t.
  - HALT: `cpu_ce` is 0.
  - RUN: `cpu_ce` = `tick`.
  - STEP: `cpu_ce` = `press`. Exactly one pulse per debounced press, independent of the prescaler.
  - BURST:
    - `burst_go` with `busy`=0 loads `rem`=burst_len. `busy` = (burst_len != 0).
    - While `busy`, each `tick` gives `cpu_ce`=1 and decrements `rem`.
    - `busy` drops in the same cycle that `rem` reaches 0.
- **Ignored or cancelled events.**
  - `burst_go` while `busy` is ignored.
  - `burst_go` outside BURST mode is ignored.
  - Leaving BURST mode clears `rem` and `busy`.
  - `press` in the same cycle as a mode change is discarded.
- **Halt flag.**
  - `halt_req` sets `halted`, which also clears `rem` and `busy`.
  - `halted` clears only on `rst`, or when `mode`=HALT with `halt_req` low.
- **Counter.** `ce_count` increments by 1 on every cycle in which `cpu_ce`=1, and wraps from 2^CNT_W-1 to 0.

## Timing
- **Reset values.** `rst` is sampled on the rising edge of `clk`. All state returns to its reset value on the next edge:
  - `cpu_ce`=0, `busy`=0, `halted`=0, `state`=HALT.
  - `ce_count`=0, `pre`=0, `rem`=0.
  - Synchronisers and debounced level = 0.
- **Reset mid-operation.** Reset in the middle of a burst or a debounce window aborts it with no further `cpu_ce`.
- **`cpu_ce` latency.** `cpu_ce` is registered: a `tick`, `press` or burst condition at cycle t appears as `cpu_ce` at t+1.
- **Pulse width.** `cpu_ce` is never high for more than one cycle per qualifying event.
- **Button latency.** From a clean `step_btn` rise to `cpu_ce` is 2 (sync) + 2^DEB_W (debounce) + 1 (edge) + 1 (register) cycles.
- **`halt_req` priority.** `halt_req` at t suppresses `cpu_ce` at t+1, even if a `tick` occurs at t.
- **Prescaler and `div_sel`.** The prescaler is not reset on mode changes. A `div_sel` change takes effect on the next cycle's `tick` compare.

## Structure
- Package `cpu_clock_pkg`:
  - `mode_t` / `state_t` enumerations (HALT=0, RUN=1, STEP=2, BURST=3).
  - Default parameter constants.
- Sub-module `btn_debounce` (parameter DEB_W):
  - Ports `clk`, `rst`, `raw`, `level`, `rise`.
  - Contains the synchroniser, stability counter and edge detector.
- Top-level integration: `cpu_ce` feeds the `load`/increment enables of the existing registers, which then all run on `clk`. `state[1]` drives the debug LED.

## Test plan
- **RUN rate:** DEB_W=4, mode=RUN, div_sel=2 for 40 cycles -> `cpu_ce` high once every 4 cycles, 10 pulses, `ce_count`=10.
- **Clean step:** mode=STEP, `step_btn` held high for 40 cycles -> exactly one `cpu_ce`, 20 cycles after the rise (2+16+1+1).
- **Bounce rejection:** mode=STEP, `step_btn` toggling every 5 cycles for 100 cycles, then low -> zero pulses, `ce_count` unchanged.
- **Burst:** mode=BURST, div_sel=0, burst_len=5, `burst_go` pulse -> 5 consecutive `cpu_ce`, `busy` high for 5 cycles. A second `burst_go` at pulse 3 is ignored. burst_len=0 -> no pulse, `busy` stays 0.
- **Halt mid-burst:** burst_len=200, `halt_req` after 7 pulses -> no `cpu_ce` from the next cycle, `halted`=1, `busy`=0. Then mode=HALT -> `halted`=0.
- **Reset and wrap:** `rst` mid-RUN -> all outputs at reset values on the next edge. With CNT_W=4, 17 pulses -> `ce_count`=1.
